// File: rtl/led_fade_ctrl.sv
// Command-driven 8-channel LED fade controller feeding a shared 8-bit PWM compare.
// Build macro LED_FADE_GAMMA_EN selects a squared (gamma) compare instead of linear.
module led_fade_ctrl #(
  parameter int TICK_DIV = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_ch,
  input  logic [7:0] cmd_duty,
  input  logic [3:0] cmd_step,
  output logic [7:0] led,
  output logic [7:0] busy,
  output logic [7:0] done
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_APPLY = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_lat_ch;
  logic [7:0]     r_lat_duty;
  logic [3:0]     r_lat_step;
  logic [7:0]     r_pwm_ctr;
  logic [TW-1:0]  r_tick_ctr;
  logic           w_tick;
  logic [7:0]     r_duty     [8];
  logic [7:0]     r_target   [8];
  logic [3:0]     r_step     [8];
  logic [3:0]     r_rate_cnt [8];
  logic [7:0]     w_duty_nxt   [8];
  logic [7:0]     w_target_nxt [8];
  logic [3:0]     w_step_nxt   [8];
  logic [3:0]     w_rate_nxt   [8];
  logic [7:0]     w_cmp_duty   [8];
  logic [7:0]     r_busy;
  logic [7:0]     r_done;
  logic [7:0]     r_led;
  logic [7:0]     w_busy_nxt;
  logic [7:0]     w_done_nxt;
  logic [7:0]     w_led_nxt;

  assign w_tick    = (r_tick_ctr == TICK_LAST);
  assign cmd_ready = (r_state == ST_IDLE);
  assign led       = r_led;
  assign busy      = r_busy;
  assign done      = r_done;

  // Command FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command FSM next state: accept in IDLE, apply for exactly one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = cmd_valid ? ST_APPLY : ST_IDLE;
      ST_APPLY: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Command latch and free-running PWM / tick counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat_ch   <= 3'd0;
      r_lat_duty <= 8'd0;
      r_lat_step <= 4'd0;
      r_pwm_ctr  <= 8'd0;
      r_tick_ctr <= '0;
    end else begin
      if ((r_state == ST_IDLE) && cmd_valid) begin
        r_lat_ch   <= cmd_ch;
        r_lat_duty <= cmd_duty;
        r_lat_step <= cmd_step;
      end else begin
        r_lat_ch   <= r_lat_ch;
        r_lat_duty <= r_lat_duty;
        r_lat_step <= r_lat_step;
      end
      r_pwm_ctr  <= r_pwm_ctr + 8'd1;
      r_tick_ctr <= w_tick ? '0 : r_tick_ctr + TW'(1);
    end
  end

  // Per-channel apply/ramp; an APPLY on a channel masks that channel's tick
  always_comb begin
    w_duty_nxt   = r_duty;
    w_target_nxt = r_target;
    w_step_nxt   = r_step;
    w_rate_nxt   = r_rate_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if ((r_state == ST_APPLY) && (r_lat_ch == 3'(i))) begin
        w_target_nxt[i] = r_lat_duty;
        w_step_nxt[i]   = r_lat_step;
        w_rate_nxt[i]   = 4'd0;
        if ((r_lat_step == 4'd0) || (r_lat_duty == r_duty[i])) begin
          w_duty_nxt[i] = r_lat_duty;
          w_busy_nxt[i] = 1'b0;
          w_done_nxt[i] = 1'b1;
        end else begin
          w_busy_nxt[i] = 1'b1;
        end
      end else if (w_tick && r_busy[i]) begin
        if (r_rate_cnt[i] == r_step[i]) begin
          w_rate_nxt[i] = 4'd0;
          w_duty_nxt[i] = (r_duty[i] > r_target[i]) ? (r_duty[i] - 8'd1) : (r_duty[i] + 8'd1);
          if (w_duty_nxt[i] == r_target[i]) begin
            w_busy_nxt[i] = 1'b0;
            w_done_nxt[i] = 1'b1;
          end else begin
            w_busy_nxt[i] = 1'b1;
          end
        end else begin
          w_rate_nxt[i] = r_rate_cnt[i] + 4'd1;
        end
      end else begin
        w_rate_nxt[i] = r_rate_cnt[i];
      end
    end
  end

  // Compare value per channel: raw duty or upper byte of duty squared
  always_comb begin
    for (int i = 0; i < 8; i++) begin
`ifdef LED_FADE_GAMMA_EN
      w_cmp_duty[i] = 8'((16'(r_duty[i]) * 16'(r_duty[i])) >> 8);
`else
      w_cmp_duty[i] = r_duty[i];
`endif
    end
  end

  // Strict compare against the PWM counter
  always_comb begin
    w_led_nxt = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_led_nxt[i] = (w_cmp_duty[i] > r_pwm_ctr);
    end
  end

  // Channel state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_duty[i]     <= 8'd0;
        r_target[i]   <= 8'd0;
        r_step[i]     <= 4'd0;
        r_rate_cnt[i] <= 4'd0;
      end
      r_busy <= 8'h00;
      r_done <= 8'h00;
      r_led  <= 8'h00;
    end else begin
      r_duty     <= w_duty_nxt;
      r_target   <= w_target_nxt;
      r_step     <= w_step_nxt;
      r_rate_cnt <= w_rate_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_led      <= w_led_nxt;
    end
  end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Self-checking bench for led_fade_ctrl: closed-form ramp model, vector table, corner sequences.
module tb_led_fade_ctrl;
  localparam int TD = 4;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_ch;
  logic [7:0] cmd_duty;
  logic [3:0] cmd_step;
  logic [7:0] led;
  logic [7:0] busy;
  logic [7:0] done;

  led_fade_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_duty(cmd_duty), .cmd_step(cmd_step),
    .led(led), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each channel ramps from m_start toward m_tgt, one LSB per (step+1) ticks since apply.
  int   e;
  int   m_start [8];
  int   m_tgt   [8];
  int   m_stp   [8];
  int   m_ticks [8];
  logic m_pend;
  int   m_pch, m_pduty, m_pstep;
  logic m_ready;
  logic [7:0] m_led, m_done;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int m_dist(input int i);
    return (m_tgt[i] > m_start[i]) ? (m_tgt[i] - m_start[i]) : (m_start[i] - m_tgt[i]);
  endfunction

  function automatic int m_moved(input int i);
    int mv;
    mv = m_ticks[i] / (m_stp[i] + 1);
    return (mv > m_dist(i)) ? m_dist(i) : mv;
  endfunction

  function automatic int m_duty(input int i);
    return (m_tgt[i] >= m_start[i]) ? (m_start[i] + m_moved(i)) : (m_start[i] - m_moved(i));
  endfunction

  function automatic logic m_busy(input int i);
    return m_moved(i) < m_dist(i);
  endfunction

  function automatic logic [7:0] m_busy_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_busy(i);
    return v;
  endfunction

  function automatic int gam(input int d);
`ifdef LED_FADE_GAMMA_EN
    return (d * d) / 256;
`else
    return d;
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_start[i] = 0; m_tgt[i] = 0; m_stp[i] = 0; m_ticks[i] = 0;
    end
    e = 0; m_pend = 1'b0; m_ready = 1'b1; m_led = 8'h00; m_done = 8'h00;
  endtask

  // One clock: check ready before the edge, advance the model at the edge, check outputs after.
  task automatic cyc();
    int   pd [8];
    logic tk, hs;
    hs = cmd_valid && m_ready;
    chk("cmd_ready", int'(cmd_ready), int'(m_ready));
    for (int i = 0; i < 8; i++) pd[i] = m_duty(i);
    tk = ((e % TD) == (TD - 1));
    @(posedge clk);
    m_done = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (m_pend && (m_pch == i)) begin
        m_start[i] = (m_pstep == 0) ? m_pduty : pd[i];
        m_tgt[i] = m_pduty; m_stp[i] = m_pstep; m_ticks[i] = 0;
        if ((m_pstep == 0) || (m_pduty == pd[i])) m_done[i] = 1'b1;
      end else if (tk && m_busy(i)) begin
        m_ticks[i]++;
        if (!m_busy(i)) m_done[i] = 1'b1;
      end
      m_led[i] = (gam(pd[i]) > (e % 256));
    end
    m_pend = hs;
    if (hs) begin
      m_pch = int'(cmd_ch); m_pduty = int'(cmd_duty); m_pstep = int'(cmd_step);
    end
    m_ready = !hs;
    e++;
    #1;
    chk("led", int'(led), int'(m_led));
    chk("busy", int'(busy), int'(m_busy_vec()));
    chk("done", int'(done), int'(m_done));
  endtask

  // Present a command until the model says it was accepted, bounded.
  task automatic send(input int ch, input int duty, input int stp);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_ch = 3'(ch); cmd_duty = 8'(duty); cmd_step = 4'(stp);
    for (int k = 0; k < 8 && !ok; k++) begin
      ok = m_ready;
      cyc();
    end
    cmd_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  typedef struct {
    int ch;
    int duty;
    int exp_high;
  } vec_t;

  vec_t vecs [6];
  int cnt_a, cnt_b, cnt_c;
  int d1_at, d2_at;
  int rdy [4];

  initial begin
`ifdef LED_FADE_GAMMA_EN
    vecs[0] = '{3, 64, 16};  vecs[1] = '{6, 255, 254}; vecs[2] = '{1, 0, 0};
    vecs[3] = '{0, 1, 0};    vecs[4] = '{7, 128, 64};  vecs[5] = '{3, 64, 16};
`else
    vecs[0] = '{3, 64, 64};  vecs[1] = '{6, 255, 255}; vecs[2] = '{1, 0, 0};
    vecs[3] = '{0, 1, 1};    vecs[4] = '{7, 128, 128}; vecs[5] = '{3, 64, 64};
`endif
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = 3'd0; cmd_duty = 8'd0; cmd_step = 4'd0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_reset();

    // Test 1: reset between edges, then LEDs stay dark for 512 clocks
    repeat (20) cyc();
    #2 rst = 1'b0;
    #1;
    chk("t1_rst_led", int'(led), 0);
    chk("t1_rst_busy", int'(busy), 0);
    chk("t1_rst_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
    cnt_a = 0;
    for (int k = 0; k < 512; k++) begin
      cyc();
      if (led != 8'h00) cnt_a++;
    end
    chk("t1_led_dark", cnt_a, 0);

    // Test 2: immediate-set vectors, high time over one PWM period
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].ch, vecs[v].duty, 0);
      cyc();
      cnt_b = int'(done[vecs[v].ch]);
      cnt_a = 0; cnt_c = int'(busy[vecs[v].ch]);
      for (int k = 0; k < 256; k++) begin
        cyc();
        cnt_a += int'(led[vecs[v].ch]);
        cnt_b += int'(done[vecs[v].ch]);
        cnt_c += int'(busy[vecs[v].ch]);
      end
      chk("t2_high_count", cnt_a, vecs[v].exp_high);
      chk("t2_done_once", cnt_b, 1);
      chk("t2_no_busy", cnt_c, 0);
    end

    // Test 3: ramp ch0 0->10 at step 1, apply edge aligned to a tick edge
    send(0, 0, 0);
    repeat (3) cyc();
    while ((e % TD) != 2) cyc();
    send(0, 10, 1);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 100; k++) begin
      cyc();
      cnt_a += int'(busy[0]);
      cnt_b += int'(done[0]);
    end
    chk("t3_busy_clocks", cnt_a, 80);
    chk("t3_done_once", cnt_b, 1);

    // Test 4: retarget down to 2 at step 2 while passing duty 5
    send(0, 0, 0);
    repeat (3) cyc();
    send(0, 10, 1);
    cnt_b = 0;
    for (int k = 0; k < 200 && m_duty(0) != 5; k++) begin
      cyc();
      cnt_b += int'(done[0]);
    end
    chk("t4_reach5", m_duty(0), 5);
    send(0, 2, 2);
    cnt_b += int'(done[0]);
    for (int k = 0; k < 80; k++) begin
      cyc();
      cnt_b += int'(done[0]);
    end
    chk("t4_done_once", cnt_b, 1);
    chk("t4_idle", int'(busy[0]), 0);

    // Test 5: back-to-back commands with cmd_valid held
    d1_at = -1; d2_at = -1;
    for (int k = 0; k < 8; k++) begin
      cmd_valid = (k < 3);
      cmd_ch = (k == 0) ? 3'd1 : 3'd2; cmd_duty = 8'd200; cmd_step = 4'd0;
      if (k < 4) rdy[k] = int'(cmd_ready);
      cyc();
      if (done[1] && d1_at < 0) d1_at = k;
      if (done[2] && d2_at < 0) d2_at = k;
    end
    cmd_valid = 1'b0;
    chk("t5_ready0", rdy[0], 1);
    chk("t5_ready1", rdy[1], 0);
    chk("t5_ready2", rdy[2], 1);
    chk("t5_ready3", rdy[3], 0);
    chk("t5_done1_at", d1_at, 1);
    chk("t5_done_gap", d2_at - d1_at, 2);

    // Test 6: async reset in the middle of a ramp
    send(4, 200, 3);
    repeat (30) cyc();
    chk("t6_busy_pre", int'(busy[4]), 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_led", int'(led), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
    cnt_b = 0;
    for (int k = 0; k < 300; k++) begin
      cyc();
      cnt_b += int'(done != 8'h00);
    end
    chk("t6_no_stale_done", cnt_b, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      cmd_valid = ($urandom_range(0, 9) == 0);
      cmd_ch    = 3'($urandom_range(0, 7));
      cmd_duty  = 8'($urandom_range(0, 255));
      cmd_step  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 3));
      cyc();
    end
    cmd_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
